// File: rtl/noc_pkg.sv
// +----------------------------------------------------------------------+
// | noc_pkg : port indices, idle select code and allocator state enum    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package noc_pkg;

  localparam int PORT_N = 0;
  localparam int PORT_S = 1;
  localparam int PORT_E = 2;
  localparam int PORT_W = 3;
  localparam int PORT_L = 4;

  localparam logic [2:0] SEL_IDLE = 3'd7;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } alloc_state_t;

endpackage

`default_nettype wire

// File: rtl/switch_allocator_if.sv
// +----------------------------------------------------------------------+
// | switch_allocator_if : request/grant bundle between router and alloc  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

interface switch_allocator_if #(
  parameter int NPORTS = 5,
  parameter int SEL_W  = 3
);

  logic [NPORTS-1:0]        valid_i;
  logic [NPORTS*NPORTS-1:0] req_i;
  logic [NPORTS-1:0]        tail_i;
  logic [NPORTS-1:0]        out_full_i;
  logic [NPORTS*SEL_W-1:0]  out_sel_o;
  logic [NPORTS-1:0]        out_en_o;
  logic [NPORTS-1:0]        in_pop_o;
  logic [NPORTS-1:0]        credit_o;
  logic [NPORTS-1:0]        lock_o;

  modport master (
    output valid_i, req_i, tail_i, out_full_i,
    input  out_sel_o, out_en_o, in_pop_o, credit_o, lock_o
  );

  modport slave (
    input  valid_i, req_i, tail_i, out_full_i,
    output out_sel_o, out_en_o, in_pop_o, credit_o, lock_o
  );

endinterface

`default_nettype wire

// File: rtl/switch_allocator_rr_pick.sv
// +----------------------------------------------------------------------+
// | rr_pick : first set request at or after ptr, searching upward mod N  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module rr_pick #(
  parameter int N     = 5,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int off = 0; off < N; off++) begin
      if (!found && req[(int'(ptr) + off) % N]) begin
        found                        = 1'b1;
        gnt[(int'(ptr) + off) % N]   = 1'b1;
        idx                          = IDX_W'((int'(ptr) + off) % N);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/switch_allocator.sv
// +----------------------------------------------------------------------+
// | switch_allocator : packet-granular round-robin allocator, 5 ports    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module switch_allocator
  import noc_pkg::*;
#(
  parameter int NPORTS = 5,
  parameter int SEL_W  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  switch_allocator_if.slave    bus
);

  logic [NPORTS-1:0]       req_lo [NPORTS];
  logic [NPORTS-1:0]       gnt    [NPORTS];
  logic [NPORTS-1:0]       en;
  logic [NPORTS-1:0]       locked;
  logic [NPORTS*SEL_W-1:0] sel;
  logic [NPORTS-1:0]       pop;

  // Only the lowest requested output of a valid input counts, so an input
  // can never win two outputs in the same cycle.
  generate
    for (genvar i = 0; i < NPORTS; i++) begin : g_in
      logic [NPORTS-1:0] r;
      assign r         = bus.valid_i[i] ? bus.req_i[i*NPORTS +: NPORTS] : '0;
      assign req_lo[i] = r & (~r + NPORTS'(1));
    end
  endgenerate

  generate
    for (genvar o = 0; o < NPORTS; o++) begin : g_out
      alloc_state_t      state;
      logic [SEL_W-1:0]  ptr;
      logic [SEL_W-1:0]  owner;
      logic [SEL_W-1:0]  pick_idx;
      logic [SEL_W-1:0]  win_idx;
      logic [NPORTS-1:0] pick_gnt;
      logic [NPORTS-1:0] col;
      logic              pick_found;
      logic              fire;

      for (genvar i = 0; i < NPORTS; i++) begin : g_col
        assign col[i] = req_lo[i][o];
      end

      rr_pick #(
        .N     (NPORTS),
        .IDX_W (SEL_W)
      ) u_pick (
        .req   (col),
        .ptr   (ptr),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .found (pick_found)
      );

      always_comb begin
        fire    = 1'b0;
        win_idx = pick_idx;
        if (state == IDLE) begin
          fire = pick_found;
        end else begin
          win_idx = owner;
          fire    = col[owner];
        end
        if (bus.out_full_i[o] || rst) begin
          fire = 1'b0;
        end
      end

      assign gnt[o] = !fire           ? '0 :
                      (state == IDLE) ? pick_gnt :
                                        (NPORTS'(1) << owner);
      assign en[o]                    = fire;
      assign sel[o*SEL_W +: SEL_W]    = fire ? win_idx : SEL_IDLE;
      assign locked[o]                = (state == LOCKED) && !rst;

      always_ff @(posedge clk) begin
        if (rst) begin
          state <= IDLE;
          ptr   <= '0;
          owner <= '0;
        end else if (fire) begin
          if (state == IDLE) begin
            ptr <= (pick_idx == SEL_W'(NPORTS - 1)) ? '0 : pick_idx + SEL_W'(1);
            if (!bus.tail_i[pick_idx]) begin
              state <= LOCKED;
              owner <= pick_idx;
            end
          end else if (bus.tail_i[owner]) begin
            state <= IDLE;
          end
        end
      end
    end
  endgenerate

  always_comb begin
    pop = '0;
    for (int o = 0; o < NPORTS; o++) begin
      pop = pop | gnt[o];
    end
  end

  assign bus.out_en_o  = en;
  assign bus.out_sel_o = sel;
  assign bus.in_pop_o  = pop;
  assign bus.credit_o  = pop;
  assign bus.lock_o    = locked;

endmodule

`default_nettype wire

// File: tb/tb_switch_allocator.sv
// +----------------------------------------------------------------------+
// | tb_switch_allocator : directed self-checking bench for the allocator |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_switch_allocator;
  import noc_pkg::*;

  localparam int NP = 5;

  logic clk = 1'b0;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;

  switch_allocator_if #(.NPORTS(NP), .SEL_W(3)) bus ();

  switch_allocator #(.NPORTS(NP), .SEL_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [24:0] rq(int i, int o);
    logic [24:0] v;
    v          = '0;
    v[i*NP+o]  = 1'b1;
    return v;
  endfunction

  function automatic logic [31:0] fld(logic [14:0] v, int o);
    return 32'(v[o*3 +: 3]);
  endfunction

  task automatic chk(string tag, logic [31:0] observed, logic [31:0] expected);
    vectors++;
    assert (observed === expected)
      else begin
        miscompares++;
        $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  task automatic drive(logic [4:0] v, logic [24:0] r, logic [4:0] t, logic [4:0] f);
    bus.valid_i    = v;
    bus.req_i      = r;
    bus.tail_i     = t;
    bus.out_full_i = f;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held, with a request present that must stay gated
    rst = 1'b1;
    drive(5'b00010, rq(PORT_S, PORT_L), 5'b00010, 5'b0);
    tick();
    tick();
    #2;
    chk("rst_en",     32'(bus.out_en_o), 32'h0);
    chk("rst_pop",    32'(bus.in_pop_o), 32'h0);
    chk("rst_credit", 32'(bus.credit_o), 32'h0);
    chk("rst_lock",   32'(bus.lock_o),   32'h0);
    chk("rst_sel",    32'(bus.out_sel_o), 32'h7FFF);

    // Basic arbitration: S and E both want L
    tick();
    rst = 1'b0;
    drive(5'b00110, rq(PORT_S, PORT_L) | rq(PORT_E, PORT_L), 5'b00110, 5'b0);
    #2;
    chk("basic0_sel", fld(bus.out_sel_o, PORT_L), 32'd1);
    chk("basic0_pop", 32'(bus.in_pop_o), 32'h02);
    tick();
    #2;
    chk("basic1_sel", fld(bus.out_sel_o, PORT_L), 32'd2);
    chk("basic1_pop", 32'(bus.in_pop_o), 32'h04);

    // Packet lock: L holds E for three flits while S waits
    tick();
    drive(5'b10000, rq(PORT_L, PORT_E), 5'b00000, 5'b0);
    #2;
    chk("lock0_sel",  fld(bus.out_sel_o, PORT_E), 32'd4);
    chk("lock0_pop",  32'(bus.in_pop_o), 32'h10);
    chk("lock0_lock", 32'(bus.lock_o), 32'h00);
    tick();
    drive(5'b10010, rq(PORT_L, PORT_E) | rq(PORT_S, PORT_E), 5'b00010, 5'b0);
    #2;
    chk("lock1_sel",  fld(bus.out_sel_o, PORT_E), 32'd4);
    chk("lock1_pop",  32'(bus.in_pop_o), 32'h10);
    chk("lock1_lock", 32'(bus.lock_o), 32'h04);
    tick();
    drive(5'b10010, rq(PORT_L, PORT_E) | rq(PORT_S, PORT_E), 5'b10010, 5'b0);
    #2;
    chk("lock2_sel",  fld(bus.out_sel_o, PORT_E), 32'd4);
    chk("lock2_pop",  32'(bus.in_pop_o), 32'h10);
    chk("lock2_lock", 32'(bus.lock_o), 32'h04);
    tick();
    drive(5'b00010, rq(PORT_S, PORT_E), 5'b00010, 5'b0);
    #2;
    chk("lock3_sel",  fld(bus.out_sel_o, PORT_E), 32'd1);
    chk("lock3_pop",  32'(bus.in_pop_o), 32'h02);
    chk("lock3_lock", 32'(bus.lock_o), 32'h00);

    // Backpressure while locked
    tick();
    drive(5'b10000, rq(PORT_L, PORT_E), 5'b00000, 5'b0);
    #2;
    chk("bp_head_sel", fld(bus.out_sel_o, PORT_E), 32'd4);
    for (int c = 0; c < 4; c++) begin
      tick();
      drive(5'b10000, rq(PORT_L, PORT_E), 5'b00000, 5'b00100);
      #2;
      chk("bp_full_en",   32'(bus.out_en_o), 32'h00);
      chk("bp_full_pop",  32'(bus.in_pop_o), 32'h00);
      chk("bp_full_lock", 32'(bus.lock_o),   32'h04);
    end
    tick();
    drive(5'b10000, rq(PORT_L, PORT_E), 5'b10000, 5'b0);
    #2;
    chk("bp_resume_en",  32'(bus.out_en_o), 32'h04);
    chk("bp_resume_sel", fld(bus.out_sel_o, PORT_E), 32'd4);
    chk("bp_resume_pop", 32'(bus.in_pop_o), 32'h10);

    // Parallel allocation: S->E, E->S, L->N
    tick();
    drive(5'b10110, rq(PORT_S, PORT_E) | rq(PORT_E, PORT_S) | rq(PORT_L, PORT_N),
          5'b10110, 5'b0);
    #2;
    chk("par_en",     32'(bus.out_en_o),  32'h07);
    chk("par_pop",    32'(bus.in_pop_o),  32'h16);
    chk("par_credit", 32'(bus.credit_o),  32'h16);
    chk("par_sel",    32'(bus.out_sel_o), 32'h7E54);

    // Pointer for N wrapped to 0 after granting L, so N beats L
    tick();
    drive(5'b10001, rq(PORT_N, PORT_N) | rq(PORT_L, PORT_N), 5'b10001, 5'b0);
    #2;
    chk("wrap_sel", fld(bus.out_sel_o, PORT_N), 32'd0);
    chk("wrap_pop", 32'(bus.in_pop_o), 32'h01);

    // Multi-hot request from W: only the lowest output (E) is honoured
    tick();
    drive(5'b01000, rq(PORT_W, PORT_E) | rq(PORT_W, PORT_L), 5'b01000, 5'b0);
    #2;
    chk("multi_en",    32'(bus.out_en_o), 32'h04);
    chk("multi_sel_e", fld(bus.out_sel_o, PORT_E), 32'd3);
    chk("multi_sel_l", fld(bus.out_sel_o, PORT_L), 32'd7);

    // Reset mid-packet drops the lock
    tick();
    drive(5'b10000, rq(PORT_L, PORT_E), 5'b00000, 5'b0);
    #2;
    chk("rmid_head_sel", fld(bus.out_sel_o, PORT_E), 32'd4);
    tick();
    chk("rmid_locked", 32'(bus.lock_o), 32'h04);
    rst = 1'b1;
    #1;
    chk("rmid_rst_lock", 32'(bus.lock_o),   32'h00);
    chk("rmid_rst_en",   32'(bus.out_en_o), 32'h00);
    tick();
    rst = 1'b0;
    drive(5'b00010, rq(PORT_S, PORT_E), 5'b00010, 5'b0);
    #2;
    chk("rmid_post_lock", 32'(bus.lock_o), 32'h00);
    chk("rmid_post_sel",  fld(bus.out_sel_o, PORT_E), 32'd1);
    chk("rmid_post_pop",  32'(bus.in_pop_o), 32'h02);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
